// File: rtl/tx_payload_sched.sv
`default_nettype none
// ============================================================================
// Module   : tx_payload_sched
// Purpose  : Per-frame sequencer for the tx payload generator. Accepts a frame
//            request in IDLE, latches the pattern config, pulses payload_pre to
//            load the generator seed, waits one alignment cycle, then streams
//            len_words words downstream under valid/ready backpressure. The
//            generator is advanced (payload_valid) only on accepted words.
// Ports    : clk, rst_n (sync, active low), gen_en (freeze when low)
//            frame_req/frame_ack, len_words, cfg_type, cfg_seed,
//            cfg_seed_incr, cfg_err_inj, cfg_err_period
//            payload_pre/seed/type/err_inj/valid -> generator
//            word_valid/word_ready/word_sop/word_eop -> downstream
//            busy, frame_cnt (completed frames)
// Options  : TX_PAYLOAD_ERR_SCHED_EN - periodic error injection using a
//            16-bit frame modulo counter; otherwise cfg_err_inj is latched.
// Revision : 1.0 - initial release
// ============================================================================
module tx_payload_sched #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_en,
  input  logic             frame_req,
  output logic             frame_ack,
  input  logic [LEN_W-1:0] len_words,
  input  logic [3:0]       cfg_type,
  input  logic [31:0]      cfg_seed,
  input  logic             cfg_seed_incr,
  input  logic             cfg_err_inj,
  input  logic [15:0]      cfg_err_period,
  output logic             payload_pre,
  output logic [31:0]      payload_seed,
  output logic [3:0]       payload_type,
  output logic             payload_err_inj,
  output logic             payload_valid,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_sop,
  output logic             word_eop,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ALIGN = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_err_hit;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic [31:0]      r_seed;
  logic [3:0]       r_type;
  logic             r_err;
  logic             r_seed_vld;   // a seed has been issued since reset
  logic [CNT_W-1:0] r_frame_cnt;

  assign w_last = (r_word_cnt == (r_len - LEN_W'(1)));

  // Next-state logic; every transition is qualified by gen_en so a low
  // gen_en freezes the sequencer exactly where it is.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (gen_en && rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (frame_req) begin
            w_accept    = 1'b1;
            w_state_nxt = S_PRE;
          end
        end
        S_PRE:   w_state_nxt = S_ALIGN;
        S_ALIGN: w_state_nxt = S_DATA;
        S_DATA: begin
          if (word_ready && w_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_seed      <= '0;
      r_type      <= '0;
      r_err       <= 1'b0;
      r_seed_vld  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_len      <= (len_words == '0) ? LEN_W'(1) : len_words;
        r_type     <= cfg_type;
        r_err      <= w_err_hit;
        r_seed     <= (r_seed_vld && cfg_seed_incr) ? (r_seed + 32'd1) : cfg_seed;
        r_seed_vld <= 1'b1;
        r_word_cnt <= '0;
      end else if (payload_valid) begin
        r_word_cnt <= r_word_cnt + LEN_W'(1);
      end
      if (gen_en && (r_state == S_DONE)) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

`ifdef TX_PAYLOAD_ERR_SCHED_EN
  // Position of the next accepted frame within the error period. The
  // ">=" wrap keeps the counter in range if the period is lowered.
  logic [15:0] r_err_mod;

  assign w_err_hit = cfg_err_inj && (cfg_err_period != 16'd0) &&
                     (r_err_mod == (cfg_err_period - 16'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_mod <= '0;
    end else if (w_accept) begin
      if ((cfg_err_period == 16'd0) || (r_err_mod >= (cfg_err_period - 16'd1))) begin
        r_err_mod <= '0;
      end else begin
        r_err_mod <= r_err_mod + 16'd1;
      end
    end
  end
`else
  logic w_unused_period;
  assign w_unused_period = ^cfg_err_period;
  assign w_err_hit       = cfg_err_inj;
`endif

  assign frame_ack       = w_accept;
  assign payload_pre     = gen_en && (r_state == S_PRE);
  assign word_valid      = gen_en && (r_state == S_DATA);
  assign payload_valid   = word_valid && word_ready;
  assign word_sop        = (r_state == S_DATA) && (r_word_cnt == '0);
  assign word_eop        = (r_state == S_DATA) && w_last;
  assign payload_seed    = r_seed;
  assign payload_type    = r_type;
  assign payload_err_inj = r_err;
  assign busy            = (r_state != S_IDLE);
  assign frame_cnt       = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tx_payload_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_payload_sched
// Purpose  : Self-checking bench for tx_payload_sched. A frame-level model
//            (seed sequence, error schedule, frame count, expected word
//            positions) predicts every observed output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_payload_sched;
  localparam int LEN_W = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             gen_en;
  logic             frame_req;
  logic             frame_ack;
  logic [LEN_W-1:0] len_words;
  logic [3:0]       cfg_type;
  logic [31:0]      cfg_seed;
  logic             cfg_seed_incr;
  logic             cfg_err_inj;
  logic [15:0]      cfg_err_period;
  logic             payload_pre;
  logic [31:0]      payload_seed;
  logic [3:0]       payload_type;
  logic             payload_err_inj;
  logic             payload_valid;
  logic             word_valid;
  logic             word_ready;
  logic             word_sop;
  logic             word_eop;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  tx_payload_sched #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .gen_en(gen_en),
    .frame_req(frame_req), .frame_ack(frame_ack),
    .len_words(len_words), .cfg_type(cfg_type), .cfg_seed(cfg_seed),
    .cfg_seed_incr(cfg_seed_incr), .cfg_err_inj(cfg_err_inj),
    .cfg_err_period(cfg_err_period),
    .payload_pre(payload_pre), .payload_seed(payload_seed),
    .payload_type(payload_type), .payload_err_inj(payload_err_inj),
    .payload_valid(payload_valid), .word_valid(word_valid),
    .word_ready(word_ready), .word_sop(word_sop), .word_eop(word_eop),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference state
  bit          m_seed_vld;
  logic [31:0] m_seed;
  int          m_idx;
  int          m_frames;
  int          m_period;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int period);
    rst_n          = 1'b0;
    frame_req      = 1'b0;
    gen_en         = 1'b1;
    word_ready     = 1'b0;
    cfg_err_period = 16'(period);
    step();
    step();
    rst_n      = 1'b1;
    m_seed_vld = 1'b0;
    m_seed     = '0;
    m_idx      = 0;
    m_frames   = 0;
    m_period   = period;
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_eq("rst_word_valid", 64'(word_valid), 64'd0);
    check_eq("rst_pre", 64'(payload_pre), 64'd0);
    check_eq("rst_seed", 64'(payload_seed), 64'd0);
    check_eq("rst_type", 64'(payload_type), 64'd0);
    check_eq("rst_err", 64'(payload_err_inj), 64'd0);
    check_eq("rst_ack", 64'(frame_ack), 64'd0);
  endtask

  // mode: 0 = full rate, 1 = random ready/gen_en, 2 = gen_en low 5 cycles
  // at word 3, 3 = ready pattern 1,0,0,1,1
  task automatic run_frame(input int len, input logic [3:0] typ, input logic [31:0] seed,
                           input bit incr, input bit err, input int mode);
    int          elen;
    int          k;
    int          c;
    int          stall;
    logic [31:0] eseed;
    bit          eerr;
    logic [4:0]  pat;
    pat  = 5'b11001;
    elen = (len == 0) ? 1 : len;

    step();
    gen_en        = 1'b1;
    frame_req     = 1'b1;
    len_words     = 16'(len);
    cfg_type      = typ;
    cfg_seed      = seed;
    cfg_seed_incr = incr;
    cfg_err_inj   = err;
    word_ready    = 1'b1;
    eseed      = (m_seed_vld && incr) ? (m_seed + 32'd1) : seed;
    m_seed     = eseed;
    m_seed_vld = 1'b1;
`ifdef TX_PAYLOAD_ERR_SCHED_EN
    eerr = err && (m_period != 0) && ((m_idx % m_period) == (m_period - 1));
`else
    eerr = err;
`endif
    m_idx++;
    @(negedge clk);
    check_eq("req_ack", 64'(frame_ack), 64'd1);
    check_eq("req_busy", 64'(busy), 64'd0);

    // PRE: scramble config and keep requesting; both must be ignored
    step();
    frame_req     = 1'b1;
    cfg_seed      = $urandom;
    cfg_type      = ~typ;
    len_words     = 16'($urandom);
    cfg_err_inj   = ~err;
    cfg_seed_incr = ~incr;
    @(negedge clk);
    check_eq("pre_pulse", 64'(payload_pre), 64'd1);
    check_eq("pre_ack", 64'(frame_ack), 64'd0);
    check_eq("pre_seed", 64'(payload_seed), 64'(eseed));
    check_eq("pre_type", 64'(payload_type), 64'(typ));
    check_eq("pre_err", 64'(payload_err_inj), 64'(eerr));
    check_eq("pre_valid", 64'(word_valid), 64'd0);

    // ALIGN
    step();
    @(negedge clk);
    check_eq("align_pre", 64'(payload_pre), 64'd0);
    check_eq("align_valid", 64'(word_valid), 64'd0);
    check_eq("align_busy", 64'(busy), 64'd1);

    // DATA
    k     = 0;
    c     = 0;
    stall = 0;
    while ((k < elen) && (c < 2000)) begin
      step();
      frame_req = 1'($urandom);
      case (mode)
        1: begin
          gen_en     = ($urandom % 8) != 0;
          word_ready = 1'($urandom);
        end
        2: begin
          gen_en     = !((k == 3) && (stall < 5));
          word_ready = 1'b1;
          if (!gen_en) stall++;
        end
        3: begin
          gen_en     = 1'b1;
          word_ready = (c < 5) ? pat[c] : 1'b1;
        end
        default: begin
          gen_en     = 1'b1;
          word_ready = 1'b1;
        end
      endcase
      @(negedge clk);
      check_eq("data_ack", 64'(frame_ack), 64'd0);
      if (!gen_en) begin
        check_eq("frz_valid", 64'(word_valid), 64'd0);
        check_eq("frz_pvalid", 64'(payload_valid), 64'd0);
      end else begin
        check_eq("word_valid", 64'(word_valid), 64'd1);
        check_eq("word_sop", 64'(word_sop), 64'(k == 0));
        check_eq("word_eop", 64'(word_eop), 64'(k == elen - 1));
        check_eq("pvalid", 64'(payload_valid), 64'(word_ready));
        check_eq("data_seed", 64'(payload_seed), 64'(eseed));
        if (word_ready) k++;
      end
      c++;
    end
    if (k < elen) check_eq("data_timeout", 64'(k), 64'(elen));

    // DONE: request held here must be dropped
    step();
    gen_en     = 1'b1;
    frame_req  = 1'b1;
    word_ready = 1'($urandom);
    @(negedge clk);
    check_eq("done_busy", 64'(busy), 64'd1);
    check_eq("done_valid", 64'(word_valid), 64'd0);
    check_eq("done_ack", 64'(frame_ack), 64'd0);
    check_eq("done_cnt", 64'(frame_cnt), 64'(m_frames));
    m_frames++;

    step();
    frame_req = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("frame_cnt", 64'(frame_cnt), 64'(m_frames));
  endtask

  task automatic abort_frame();
    step();
    frame_req  = 1'b1;
    len_words  = 16'd10;
    gen_en     = 1'b1;
    word_ready = 1'b1;
    repeat (5) begin
      step();
      frame_req = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_pre_valid", 64'(word_valid), 64'd1);
    step();
    @(negedge clk);
    check_eq("abort_valid", 64'(word_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_cnt", 64'(frame_cnt), 64'd0);
    check_eq("abort_seed", 64'(payload_seed), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; gen_en = 1'b0; frame_req = 1'b0; len_words = '0;
    cfg_type = '0; cfg_seed = '0; cfg_seed_incr = 1'b0; cfg_err_inj = 1'b0;
    cfg_err_period = '0; word_ready = 1'b0;

    do_reset(3);
    run_frame(4, 4'h1, 32'h10, 1'b0, 1'b0, 0);
    run_frame(3, 4'h1, $urandom, 1'b0, 1'b0, 3);
    run_frame(8, 4'h2, $urandom, 1'b0, 1'b0, 2);
    run_frame(0, 4'h3, $urandom, 1'b0, 1'b0, 0);

    do_reset(3);
    run_frame(2, 4'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_frame(2, 4'h4, 32'h1234_5678, 1'b1, 1'b0, 0);

    do_reset(3);
    repeat (6) run_frame(1, 4'h0, $urandom, 1'b0, 1'b1, 0);

    abort_frame();

    do_reset($urandom_range(0, 4));
    repeat (25) run_frame($urandom_range(0, 6), 4'($urandom), $urandom,
                          1'($urandom), 1'($urandom), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
